// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: one-hot instruction indices,
// fetch FSM state encoding, default reset PC and a one-hot test helper.
package mips_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CODE_W = 32;

    // One-hot bit index of each instruction in the decoder's code vector
    localparam int unsigned OP_ADD   = 0;
    localparam int unsigned OP_ADDU  = 1;
    localparam int unsigned OP_SUB   = 2;
    localparam int unsigned OP_SUBU  = 3;
    localparam int unsigned OP_AND   = 4;
    localparam int unsigned OP_OR    = 5;
    localparam int unsigned OP_XOR   = 6;
    localparam int unsigned OP_NOR   = 7;
    localparam int unsigned OP_SLT   = 8;
    localparam int unsigned OP_SLTU  = 9;
    localparam int unsigned OP_SLL   = 10;
    localparam int unsigned OP_SRL   = 11;
    localparam int unsigned OP_SRA   = 12;
    localparam int unsigned OP_SLLV  = 13;
    localparam int unsigned OP_SRLV  = 14;
    localparam int unsigned OP_SRAV  = 15;
    localparam int unsigned OP_JR    = 16;
    localparam int unsigned OP_ADDI  = 17;
    localparam int unsigned OP_ADDIU = 18;
    localparam int unsigned OP_ANDI  = 19;
    localparam int unsigned OP_ORI   = 20;
    localparam int unsigned OP_XORI  = 21;
    localparam int unsigned OP_LW    = 22;
    localparam int unsigned OP_SW    = 23;
    localparam int unsigned OP_BEQ   = 24;
    localparam int unsigned OP_BNE   = 25;
    localparam int unsigned OP_SLTI  = 26;
    localparam int unsigned OP_SLTIU = 27;
    localparam int unsigned OP_LUI   = 28;
    localparam int unsigned OP_J     = 29;
    localparam int unsigned OP_JAL   = 30;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    // True when exactly one bit is set; X inputs propagate to X
    function automatic logic is_onehot(input logic [CODE_W-1:0] v);
        return (v != '0) && ((v & (v - CODE_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/npc_calc.sv
// Next-PC computation for the fetch stage (purely combinational).
// Ports: pc, ins, code (one-hot), alu_zero, rs_data in;
//        next_pc, pc_plus4, illegal (code not exactly one-hot) out.
module npc_calc
    import mips_pkg::*;
(
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   ins,
    input  logic [CODE_W-1:0] code,
    input  logic              alu_zero,
    input  logic [XLEN-1:0]   rs_data,
    output logic [XLEN-1:0]   next_pc,
    output logic [XLEN-1:0]   pc_plus4,
    output logic              illegal
);

    logic [XLEN-1:0] br_offset;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jmp_target;
    logic            unused_ins;

    assign pc_plus4   = pc + XLEN'(4);
    assign br_offset  = {{14{ins[15]}}, ins[15:0], 2'b00};
    assign br_target  = pc_plus4 + br_offset;
    assign jmp_target = {pc_plus4[31:28], ins[25:0], 2'b00};
    assign illegal    = !is_onehot(code);
    assign unused_ins = ^ins[31:26];

    // Target select; an illegal code falls through to sequential flow
    always_comb begin
        next_pc = pc_plus4;
        if (!illegal) begin
            if (code[OP_JR])
                next_pc = rs_data;
            else if (code[OP_BEQ] && alu_zero)
                next_pc = br_target;
            else if (code[OP_BNE] && !alu_zero)
                next_pc = br_target;
            else if (code[OP_J] || code[OP_JAL])
                next_pc = jmp_target;
        end
    end

endmodule

// File: rtl/ins_fetch.sv
// Fetch stage: owns the PC, fetches over a req/ack handshake, holds the
// instruction for the decoder until commit, then advances the PC.
// Ports: clk, rst (sync, active-high); imem_req/addr/ack/rdata memory
// handshake; ins/ins_valid to decoder; code/alu_zero/rs_data/commit from
// decode and datapath; pc, pc_plus4, illegal pulse, sticky fault out.
module ins_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [XLEN-1:0]   imem_rdata,
    output logic [XLEN-1:0]   ins,
    output logic              ins_valid,
    input  logic [CODE_W-1:0] code,
    input  logic              alu_zero,
    input  logic [XLEN-1:0]   rs_data,
    input  logic              commit,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_plus4,
    output logic              illegal,
    output logic              fault
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    fetch_state_e    state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [XLEN-1:0] pc_next, ins_next, npc;
    logic            ins_valid_next, illegal_next, fault_next, npc_illegal;

    npc_calc u_npc (
        .pc       (pc),
        .ins      (ins),
        .code     (code),
        .alu_zero (alu_zero),
        .rs_data  (rs_data),
        .next_pc  (npc),
        .pc_plus4 (pc_plus4),
        .illegal  (npc_illegal)
    );

    assign imem_addr = pc;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            ins       <= '0;
            ins_valid <= 1'b0;
            imem_req  <= 1'b0;
            illegal   <= 1'b0;
            fault     <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            ins       <= ins_next;
            ins_valid <= ins_valid_next;
            imem_req  <= (state_next == ST_FETCH);
            illegal   <= illegal_next;
            fault     <= fault_next;
            cnt       <= cnt_next;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_next     = state;
        pc_next        = pc;
        ins_next       = ins;
        ins_valid_next = ins_valid;
        illegal_next   = 1'b0;
        fault_next     = fault;
        cnt_next       = cnt;
        case (state)
            ST_IDLE: begin
                cnt_next   = '0;
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    ins_next       = imem_rdata;
                    ins_valid_next = 1'b1;
                    cnt_next       = '0;
                    state_next     = ST_EXEC;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                    if (cnt_next == CNT_W'(TIMEOUT_CYCLES)) begin
                        fault_next = 1'b1;
                        state_next = ST_HALT;
                    end
                end
            end
            ST_EXEC: begin
                if (commit) begin
                    illegal_next   = npc_illegal;
                    ins_valid_next = 1'b0;
                    // Only JR can produce a misaligned target; pc stays put
                    if (npc[1:0] != 2'b00) begin
                        fault_next = 1'b1;
                        state_next = ST_HALT;
                    end else begin
                        pc_next    = npc;
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                ins_valid_next = 1'b0;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: reset, zero-wait fetch, next-PC vector
// table, misaligned JR, wait states, timeout and mid-fetch reset.
module tb_ins_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] ins;
    logic        ins_valid;
    logic [31:0] code = '0;
    logic        alu_zero = 1'b0;
    logic [31:0] rs_data = '0;
    logic        commit = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        illegal;
    logic        fault;

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [31:0] C_JR   = 32'h0001_0000;
    localparam logic [31:0] C_ADDI = 32'h0002_0000;
    localparam logic [31:0] C_BEQ  = 32'h0100_0000;
    localparam logic [31:0] C_BNE  = 32'h0200_0000;
    localparam logic [31:0] C_J    = 32'h2000_0000;
    localparam logic [31:0] C_JAL  = 32'h4000_0000;

    typedef struct {
        logic [31:0] start_pc;
        logic [31:0] word;
        logic [31:0] code;
        logic        zero;
        logic [31:0] rs;
        logic [31:0] exp_pc;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[11];

    ins_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .code       (code),
        .alu_zero   (alu_zero),
        .rs_data    (rs_data),
        .commit     (commit),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .illegal    (illegal),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Hold reset for two edges and check reset values; leaves DUT in IDLE
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req",   32'(imem_req),  32'h0);
        chk("rst_valid", 32'(ins_valid), 32'h0);
        chk("rst_pc",    pc,             32'h0);
        chk("rst_ins",   ins,            32'h0);
        chk("rst_fault", 32'(fault),     32'h0);
        chk("rst_ill",   32'(illegal),   32'h0);
        rst = 1'b0;
    endtask

    // Wait for a request, then ack after 'waits' cycles
    task automatic do_fetch(input logic [31:0] word, input int waits);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            chk("fetch_req_timeout", 32'(imem_req), 32'h1);
            return;
        end
        repeat (waits) @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
    endtask

    task automatic do_commit(input logic [31:0] c, input logic z, input logic [31:0] rs);
        code     = c;
        alu_zero = z;
        rs_data  = rs;
        commit   = 1'b1;
        @(negedge clk);
        commit   = 1'b0;
        code     = '0;
    endtask

    task automatic goto_pc(input logic [31:0] addr);
        do_fetch(32'h0, 0);
        do_commit(C_JR, 1'b0, addr);
    endtask

    initial begin
        int cnt;
        int req_seen;

        vecs[0]  = '{32'h0000_0010, 32'h1000_FFFC, C_BEQ,        1'b1, 32'h0, 32'h0000_0004, 1'b0};
        vecs[1]  = '{32'h0000_0010, 32'h1000_FFFC, C_BEQ,        1'b0, 32'h0, 32'h0000_0014, 1'b0};
        vecs[2]  = '{32'h0000_0010, 32'h1400_FFFC, C_BNE,        1'b1, 32'h0, 32'h0000_0014, 1'b0};
        vecs[3]  = '{32'h0000_0010, 32'h1400_FFFC, C_BNE,        1'b0, 32'h0, 32'h0000_0004, 1'b0};
        vecs[4]  = '{32'h1000_0000, 32'h0800_0040, C_J,          1'b0, 32'h0, 32'h1000_0100, 1'b0};
        vecs[5]  = '{32'h1000_0000, 32'h0C00_0040, C_JAL,        1'b0, 32'h0, 32'h1000_0100, 1'b0};
        vecs[6]  = '{32'h0000_0020, 32'h0000_0008, C_JR,         1'b0, 32'h0000_0200, 32'h0000_0200, 1'b0};
        vecs[7]  = '{32'h0000_0008, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0, 32'h0000_000C, 1'b1};
        vecs[8]  = '{32'h0000_0008, 32'h0000_0000, 32'h0000_0003, 1'b0, 32'h0, 32'h0000_000C, 1'b1};
        vecs[9]  = '{32'hFFFF_FFFC, 32'h2008_0005, C_ADDI,       1'b0, 32'h0, 32'h0000_0000, 1'b0};
        vecs[10] = '{32'h0000_0010, 32'h1000_0003, C_BEQ,        1'b1, 32'h0, 32'h0000_0020, 1'b0};

        @(negedge clk);
        do_reset();

        // Zero-wait fetch of ADDI straight out of reset
        @(negedge clk);
        chk("c1_req",   32'(imem_req),  32'h1);
        chk("c1_valid", 32'(ins_valid), 32'h0);
        chk("c1_addr",  imem_addr,      32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h2008_0005;
        @(negedge clk);
        imem_ack   = 1'b0;
        chk("c2_valid", 32'(ins_valid), 32'h1);
        chk("c2_ins",   ins,            32'h2008_0005);
        chk("c2_req",   32'(imem_req),  32'h0);
        chk("c2_pc4",   pc_plus4,       32'h0000_0004);
        do_commit(C_ADDI, 1'b0, 32'h0);
        chk("addi_pc",    pc,             32'h0000_0004);
        chk("addi_valid", 32'(ins_valid), 32'h0);
        chk("addi_req",   32'(imem_req),  32'h1);
        chk("addi_addr",  imem_addr,      32'h0000_0004);

        // Next-PC vector table
        for (int i = 0; i < 11; i++) begin
            goto_pc(vecs[i].start_pc);
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].start_pc);
            do_fetch(vecs[i].word, 0);
            chk($sformatf("v%0d_valid", i), 32'(ins_valid), 32'h1);
            chk($sformatf("v%0d_pc4", i), pc_plus4, vecs[i].start_pc + 32'd4);
            do_commit(vecs[i].code, vecs[i].zero, vecs[i].rs);
            chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("v%0d_ill", i), 32'(illegal), 32'(vecs[i].exp_ill));
            chk($sformatf("v%0d_req", i), 32'(imem_req), 32'h1);
            @(negedge clk);
            chk($sformatf("v%0d_ill_end", i), 32'(illegal), 32'h0);
        end

        // Misaligned JR: fault, pc held, no further requests
        goto_pc(32'h0000_0040);
        do_fetch(32'h0, 0);
        do_commit(C_JR, 1'b0, 32'h0000_0202);
        chk("mis_fault", 32'(fault),     32'h1);
        chk("mis_pc",    pc,             32'h0000_0040);
        chk("mis_valid", 32'(ins_valid), 32'h0);
        req_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (imem_req) req_seen++;
            @(negedge clk);
        end
        chk("mis_no_req", 32'(req_seen), 32'h0);
        chk("mis_sticky", 32'(fault),    32'h1);

        // Three wait states; commit during FETCH must be ignored
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ws%0d_req", i), 32'(imem_req), 32'h1);
            chk($sformatf("ws%0d_addr", i), imem_addr, 32'h0);
            if (i < 3) begin
                code    = C_JR;
                rs_data = 32'h0000_0100;
                commit  = 1'b1;
            end else begin
                commit     = 1'b0;
                code       = '0;
                imem_ack   = 1'b1;
                imem_rdata = 32'hAAAA_5555;
            end
            @(negedge clk);
        end
        imem_ack = 1'b0;
        chk("ws_ins",   ins,            32'hAAAA_5555);
        chk("ws_valid", 32'(ins_valid), 32'h1);
        chk("ws_pc",    pc,             32'h0);
        do_commit(C_ADDI, 1'b0, 32'h0);
        chk("ws_next_pc", pc, 32'h0000_0004);

        // Memory never acks: fault after 16 FETCH cycles
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (fault) break;
            if (imem_req) cnt++;
            @(negedge clk);
        end
        chk("to_cycles", 32'(cnt),      32'd16);
        chk("to_fault",  32'(fault),    32'h1);
        chk("to_req",    32'(imem_req), 32'h0);
        chk("to_pc",     pc,            32'h0000_0004);

        // Reset asserted mid-FETCH with a coincident ack
        do_reset();
        goto_pc(32'h0000_0080);
        chk("mr_pc",  pc,             32'h0000_0080);
        chk("mr_req", 32'(imem_req),  32'h1);
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("mr_req0",  32'(imem_req),  32'h0);
        chk("mr_pc0",   pc,             32'h0);
        chk("mr_ins0",  ins,            32'h0);
        chk("mr_valid", 32'(ins_valid), 32'h0);
        rst      = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        chk("mr_req1", 32'(imem_req), 32'h1);
        chk("mr_addr", imem_addr,     32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
